stream_demux_n: RTL

- Parametrised, registered 1-to-N stream demultiplexer with a valid/ready handshake on the input and on each output.
- Each beat is routed by `in_sel` into a per-channel FIFO of depth `DEPTH`. Channels drain independently.
- Sits between a single producer (e.g. a sample source) and N consumer paths. Replaces the fixed 1:4 combinational steering with back-pressure-aware, buffered routing.

---
 rtl/stream_demux_n.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/stream_demux_n.sv
// stream_demux_n -- registered 1-to-N stream demultiplexer.
//
// Each accepted beat is steered by in_sel into a per-channel FIFO of DEPTH
// entries. Channels drain independently through their own valid/ready pair.
// A beat with in_sel >= N_OUT is accepted, discarded and counted.
//
// Optional build macro STREAM_DEMUX_BCAST_EN adds in_bcast. While it is
// high, a beat goes into every channel at once, and only when none of them
// is full.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   in_valid/ready  input handshake; in_data payload, in_sel channel index
//   in_bcast        (STREAM_DEMUX_BCAST_EN only) push into all channels
//   out_valid/ready per-channel handshake
//   out_data        channel k is at [k*DATA_W +: DATA_W]; 0 while empty
//   err_sel         sticky, set by an out-of-range in_sel
//   drop_cnt        dropped beats, saturating at 255

module stream_demux_n_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] rdata
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              pop;

  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);
  assign pop   = valid & ready;
  assign rdata = valid ? mem[rd_ptr] : '0;

  // The top never pushes into a full channel, so push needs no full guard.
  // DEPTH is a power of two, so the pointers wrap by overflowing.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset. An empty entry is never shown, because rdata is
  // gated by valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
endmodule

module stream_demux_n #(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int SEL_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic                    in_bcast,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    err_sel,
  output logic [7:0]              drop_cnt
);
  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_OUT);

  logic [N_OUT-1:0] full, push;
  logic             sel_ok, sel_full, bcast, accept, drop;

`ifdef STREAM_DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign sel_ok = ({1'b0, in_sel} < N_LIM);

  // The full flag of the selected channel is picked with a compare loop.
  // This avoids indexing full[] with an out-of-range in_sel.
  always_comb begin
    sel_full = 1'b0;
    for (int k = 0; k < N_OUT; k++)
      if (in_sel == SEL_W'(k)) sel_full = full[k];
  end

  // in_ready depends only on the full flags, never on out_ready. A full
  // channel therefore stalls for one cycle even while it pops.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (bcast)       in_ready = ~|full;
      else if (sel_ok) in_ready = !sel_full;
      else             in_ready = 1'b1;
    end
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & !bcast & !sel_ok;

  always_comb begin
    push = '0;
    for (int k = 0; k < N_OUT; k++)
      push[k] = accept & (bcast | (in_sel == SEL_W'(k)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      err_sel <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    stream_demux_n_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .wdata (in_data),
      .full  (full[k]),
      .valid (out_valid[k]),
      .ready (out_ready[k]),
      .rdata (out_data[k*DATA_W +: DATA_W])
    );
  end
endmodule
